// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall controller: FSM encoding,
// default memory-wait timeout and a counter-width helper.
package hazard_stall_unit_pkg;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_e;

    localparam int DEF_TIMEOUT = 255;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline <-> hazard unit signal bundle. The pipeline side is the master,
// the hazard unit is the slave.
interface hazard_stall_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [REG_W-1:0] id_ex_rd;
    logic             id_ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_write;
    logic             if_id_hold;
    logic             id_ex_hold;
    logic             ex_mem_hold;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd,
               id_ex_mem_read, ex_branch_taken, mem_req, mem_ready,
        input  pc_write, if_id_hold, id_ex_hold, ex_mem_hold,
               if_id_flush, id_ex_flush, mem_timeout, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd,
               id_ex_mem_read, ex_branch_taken, mem_req, mem_ready,
        output pc_write, if_id_hold, id_ex_hold, ex_mem_hold,
               if_id_flush, id_ex_flush, mem_timeout, stall_count
    );
endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: memory-wait stall, branch flush and load-use bubble.
//   state       | meaning
//   ST_RUN      | no outstanding memory access, pipeline flows
//   ST_MEM_WAIT | data access issued, waiting for mem_ready
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic           clk,
    input logic           reset,
    hazard_stall_unit_if.slave hz
);

    localparam int               WAIT_W = cnt_width(TIMEOUT);
    localparam logic [REG_W-1:0] REG_X0 = '0;

    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_q;
    logic              timeout_hit;
    logic              mem_stall;
    logic              load_use;
    logic              pc_write, if_id_hold, id_ex_hold, ex_mem_hold;
    logic              if_id_flush, id_ex_flush;
    logic [CNT_W-1:0]  stall_count;

    // x0 is hardwired zero, so a load "into" it never creates a dependency
    assign load_use = hz.id_ex_mem_read && (hz.id_ex_rd != REG_X0) &&
                      ((hz.id_uses_rs1 && (hz.id_rs1 == hz.id_ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.id_rs2 == hz.id_ex_rd)));

    always_comb begin
        state_d     = state_q;
        mem_stall   = 1'b0;
        pc_write    = 1'b0;
        if_id_hold  = 1'b0;
        id_ex_hold  = 1'b0;
        ex_mem_hold = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (hz.mem_req && !hz.mem_ready) begin
                    state_d   = ST_MEM_WAIT;
                    mem_stall = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (hz.mem_ready)
                    state_d = ST_RUN;
                else
                    mem_stall = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase

        if (mem_stall) begin
            pc_write    = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_hold  = 1'b1;
            ex_mem_hold = 1'b1;
        end else if (hz.ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    assign timeout_hit = (state_q == ST_MEM_WAIT) && (wait_cnt == WAIT_W'(TIMEOUT));

    // wait_cnt parks at TIMEOUT so a very long wait cannot wrap it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_RUN) && (state_d == ST_MEM_WAIT))
                wait_cnt <= '0;
            else if ((state_q == ST_MEM_WAIT) && (wait_cnt != WAIT_W'(TIMEOUT)))
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (timeout_hit)
                timeout_q <= 1'b1;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pc_write),
        .clear (1'b0),
        .count (stall_count)
    );

    assign hz.pc_write    = pc_write;
    assign hz.if_id_hold  = if_id_hold;
    assign hz.id_ex_hold  = id_ex_hold;
    assign hz.ex_mem_hold = ex_mem_hold;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.mem_timeout = timeout_q | timeout_hit;
    assign hz.stall_count = stall_count;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench: directed hazard scenarios plus random traffic against a
// cycle-level behavioural model of the pipeline hazard rules.
module tb_hazard_stall_unit;
    import hazard_stall_unit_pkg::*;

    localparam int TO = 4;

    logic clk;
    logic reset;

    hazard_stall_unit_if #(.REG_W(5), .CNT_W(16)) hif ();
    hazard_stall_unit_if #(.REG_W(5), .CNT_W(2))  sif ();

    assign sif.id_rs1          = hif.id_rs1;
    assign sif.id_rs2          = hif.id_rs2;
    assign sif.id_uses_rs1     = hif.id_uses_rs1;
    assign sif.id_uses_rs2     = hif.id_uses_rs2;
    assign sif.id_ex_rd        = hif.id_ex_rd;
    assign sif.id_ex_mem_read  = hif.id_ex_mem_read;
    assign sif.ex_branch_taken = hif.ex_branch_taken;
    assign sif.mem_req         = hif.mem_req;
    assign sif.mem_ready       = hif.mem_ready;

    hazard_stall_unit #(.REG_W(5), .CNT_W(16), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif.slave)
    );

    hazard_stall_unit #(.REG_W(5), .CNT_W(2)) dut_s (
        .clk   (clk),
        .reset (reset),
        .hz    (sif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        pc_write;
        logic        if_id_hold;
        logic        id_ex_hold;
        logic        ex_mem_hold;
        logic        if_id_flush;
        logic        id_ex_flush;
        logic        mem_timeout;
        logic [15:0] stall_count;
        logic [1:0]  sat_count;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // behavioural model: are we waiting on memory, which wait cycle is this,
    // has the timeout latched, how many stalled cycles so far
    bit m_wait;
    int m_n;
    bit m_sticky;
    int m_cnt;

    task automatic chk(input string tag, input string name, input logic [15:0] act, input logic [15:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", tag, name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.tag, "pc_write",    16'(hif.pc_write),    16'(e.pc_write));
            chk(e.tag, "if_id_hold",  16'(hif.if_id_hold),  16'(e.if_id_hold));
            chk(e.tag, "id_ex_hold",  16'(hif.id_ex_hold),  16'(e.id_ex_hold));
            chk(e.tag, "ex_mem_hold", 16'(hif.ex_mem_hold), 16'(e.ex_mem_hold));
            chk(e.tag, "if_id_flush", 16'(hif.if_id_flush), 16'(e.if_id_flush));
            chk(e.tag, "id_ex_flush", 16'(hif.id_ex_flush), 16'(e.id_ex_flush));
            chk(e.tag, "mem_timeout", 16'(hif.mem_timeout), 16'(e.mem_timeout));
            chk(e.tag, "stall_count", hif.stall_count,      e.stall_count);
            chk(e.tag, "sat_count",   16'(sif.stall_count), 16'(e.sat_count));
            chk(e.tag, "sat_pc_write", 16'(sif.pc_write),   16'(e.pc_write));
        end
    end

    task automatic drive(input bit rst_low, input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u1, input bit u2, input logic [4:0] rd, input bit mr,
                         input bit br, input bit mq, input bit my, input string tag);
        exp_t e;
        bit   stall, lu;
        @(posedge clk);
        #1;
        reset                   = !rst_low;
        hif.id_rs1              = rs1;
        hif.id_rs2              = rs2;
        hif.id_uses_rs1         = u1;
        hif.id_uses_rs2         = u2;
        hif.id_ex_rd            = rd;
        hif.id_ex_mem_read      = mr;
        hif.ex_branch_taken     = br;
        hif.mem_req             = mq;
        hif.mem_ready           = my;

        if (rst_low) begin
            m_wait = 0; m_n = 0; m_sticky = 0; m_cnt = 0;
        end
        // a stall happens whenever memory is (or just became) busy and not ready
        stall = (m_wait || mq) && !my;
        lu    = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));

        e.tag         = tag;
        e.pc_write    = stall || (!br && lu);
        e.if_id_hold  = stall || (!br && lu);
        e.id_ex_hold  = stall;
        e.ex_mem_hold = stall;
        e.if_id_flush = !stall && br;
        e.id_ex_flush = !stall && (br || lu);
        e.mem_timeout = m_sticky || (m_wait && m_n >= TO + 1);
        e.stall_count = 16'(m_cnt);
        e.sat_count   = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
        exp_q.push_back(e);

        if (!rst_low) begin
            if (e.mem_timeout) m_sticky = 1;
            if (e.pc_write) m_cnt++;
            if (m_wait) begin
                if (my) m_wait = 0;
                else    m_n++;
            end else if (mq && !my) begin
                m_wait = 1;
                m_n    = 1;
            end
        end
    endtask

    task automatic idle(input string tag);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic do_reset(input string tag);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        hif.id_rs1 = '0; hif.id_rs2 = '0; hif.id_uses_rs1 = 0; hif.id_uses_rs2 = 0;
        hif.id_ex_rd = '0; hif.id_ex_mem_read = 0; hif.ex_branch_taken = 0;
        hif.mem_req = 0; hif.mem_ready = 0;

        do_reset("reset");
        idle("idle0");

        drive(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, "load_use");
        idle("after_load_use");
        drive(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, "x0_no_stall");
        drive(0, 1, 7, 1, 0, 7, 1, 0, 0, 0, "unused_rs2");
        drive(0, 3, 0, 1, 0, 3, 1, 1, 0, 0, "branch_over_lu");
        idle("after_branch");

        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "mem_w1");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "mem_w2");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "mem_w3");
        drive(0, 4, 0, 1, 0, 4, 1, 0, 1, 1, "mem_ready_lu");
        idle("after_mem");

        for (int i = 0; i < 8; i++)
            drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, "timeout_wait");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "timeout_ready");
        idle("timeout_sticky");
        do_reset("timeout_reset");
        idle("timeout_cleared");

        for (int i = 0; i < 5; i++)
            drive(0, 2, 0, 1, 0, 2, 1, 0, 0, 0, "sat_stall");
        idle("sat_hold");
        idle("sat_hold2");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rnd_reset");
            end else begin
                drive(0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 9) < 6), "random");
            end
        end
        idle("final");

        @(posedge clk);
        @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
